fifo_method2: RTL and testbench
===============================

// Module: fifo_method2
// PURPOSE
//   Synchronous single-clock FIFO. Buffers DATA_WIDTH-bit words between a producer and a consumer in the same clock domain.
//   full/empty come from pointers that are one bit wider than the address ("extra MSB" method).
//   Generic buffering block for datapaths that need back-pressure status.
// PARAMETERS
//   DATA_WIDTH  8  word width in bits
//   ADDR_WIDTH  3  address bits; DEPTH = 2**ADDR_WIDTH = 8 entries
// PORTS
//   clk       in   1           rising-edge clock
//   rst       in   1           asynchronous, active-high reset
//   wr_en     in   1           write request; data_in is captured on the clk edge
//   rd_en     in   1           read request; the word appears on data_out after the edge
//   data_in   in   DATA_WIDTH  write data
//   data_out  out  DATA_WIDTH  registered read data
//   full      out  1           FIFO holds DEPTH words
//   empty     out  1           FIFO holds 0 words
// BEHAVIOUR
//   - Reset (async assert, effective immediately):
//     - wr_ptr = rd_ptr = 0, data_out = 0, empty = 1, full = 0.
//     - Memory contents are not reset.
//   - Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits address memory; the MSB is a wrap flag.
//   - empty = (wr_ptr == rd_ptr).
//   - full = (MSBs differ) && (low ADDR_WIDTH bits equal).
//   - full and empty are combinational from the registered pointers, so they update in the cycle after the accepting edge.
//   - Write accepted iff wr_en && !full:
//     - mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in
//     - wr_ptr <= wr_ptr + 1
//   - Read accepted iff rd_en && !empty:
//     - data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]]
//     - rd_ptr <= rd_ptr + 1
//     - Latency is 1 clk.
//   - data_out holds its last value when no read is accepted.
//   - Write when full: ignored; no pointer or memory change.
//   - Read when empty: ignored; data_out unchanged.
//   - Simultaneous wr_en and rd_en: each is evaluated independently against the pre-edge flags.
//     - Neither full nor empty: both are accepted and the occupancy is unchanged.
//     - Empty: only the write is accepted.
//     - Full: only the read is accepted.
//   - Pointers wrap naturally modulo 2*DEPTH, with no special handling at the boundary.
//   - Reset asserted mid-operation aborts all transfers. The FIFO returns to empty and stored data is discarded.
// CONFIGURATION
//   FIFO_METHOD2_COUNT_EN
//     - Defined: adds output port count [ADDR_WIDTH:0] = wr_ptr - rd_ptr (0..DEPTH), combinational. Reset value is 0.
//     - Undefined: no count port. All other behaviour is identical.
// STRUCTURE
//   - Package fifo_method2_pkg holds:
//     - default DATA_WIDTH and ADDR_WIDTH localparams
//     - DEPTH = 1 << ADDR_WIDTH
//     - pointer typedef logic [ADDR_WIDTH:0] ptr_t
//   - Sub-module fifo_method2_mem: DEPTH x DATA_WIDTH register array with one synchronous write port and one synchronous read port.
//   - Pointer and flag logic stays in the top module.
// TESTING
//   - Reset: hold rst=1 for 2 clks -> empty=1, full=0, data_out=0; pointers 0.
//   - Fill: write 8 words 0x11..0x88 with rd_en=0 -> full=1 after the 8th edge; empty=0.
//     A 9th write of 0xFF is ignored.
//   - Drain: read until empty -> data_out = 0x11,0x22,...,0x88, each 1 clk after its accepting edge.
//     empty=1 after the 8th read; data_out then holds 0x88.
//   - Underflow: rd_en=1 while empty for 3 clks -> data_out stays 0x88; pointers unchanged.
//   - Simultaneous: with 4 words stored, wr_en=rd_en=1 for 6 clks with new data -> occupancy stays 4.
//     Reads return the oldest data in order; no flag toggles.
//     From empty, simultaneous wr/rd -> only the write lands; empty=0 next cycle.
//   - Wrap and mid-op reset: do 20 mixed writes/reads so the pointers pass 16.
//     Flags must match a reference queue model.
//     Then assert rst mid-burst -> empty=1 immediately; a following write/read returns only the new data.

Source files
------------

// File: rtl/fifo_method2_pkg.sv
// -----------------------------------------------------------------------------
// fifo_method2_pkg
//   Shared defaults and types for the fifo_method2 block.
//   - DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default word and address widths
//   - DEF_DEPTH                       : default number of entries (1 << ADDR_WIDTH)
//   - ptr_t                           : pointer type at the default width
//                                       (address bits plus one wrap bit)
//   - depth_of()                      : entry count for a given address width
// -----------------------------------------------------------------------------
package fifo_method2_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;

    typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage : fifo_method2_pkg

// File: rtl/fifo_method2_mem.sv
// -----------------------------------------------------------------------------
// fifo_method2_mem
//   DEPTH x DATA_WIDTH register array with one synchronous write port and one
//   synchronous (registered) read port.
//   Ports:
//     clk    in  rising-edge clock
//     rst    in  asynchronous active-high reset (clears rdata only)
//     we     in  write enable
//     waddr  in  write address
//     wdata  in  write data
//     re     in  read enable; rdata loads mem[raddr] on the edge
//     raddr  in  read address
//     rdata  out registered read data, holds when re is low
//   The storage array itself is not reset.
// -----------------------------------------------------------------------------
module fifo_method2_mem
    import fifo_method2_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int MEM_DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : fifo_method2_mem

// File: rtl/fifo_method2.sv
// -----------------------------------------------------------------------------
// fifo_method2
//   Single-clock FIFO; full/empty derived from pointers one bit wider than the
//   address ("extra MSB" method).
//   Ports:
//     clk       in  rising-edge clock
//     rst       in  asynchronous active-high reset
//     wr_en     in  write request (accepted when not full)
//     rd_en     in  read request (accepted when not empty)
//     data_in   in  write data
//     data_out  out registered read data, valid one clk after the accepting edge
//     full      out FIFO holds DEPTH words
//     empty     out FIFO holds 0 words
//     count     out (only with FIFO_METHOD2_COUNT_EN) occupancy wr_ptr - rd_ptr
//   Configuration macro: FIFO_METHOD2_COUNT_EN adds the count output.
// -----------------------------------------------------------------------------
module fifo_method2
    import fifo_method2_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
`ifdef FIFO_METHOD2_COUNT_EN
    output logic [ADDR_WIDTH:0]   count,
`endif
    output logic                  empty
);

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic                wr_acc;
    logic                rd_acc;

    // Equal pointers mean empty; same address with opposite wrap bits means
    // the writer is exactly one lap ahead, i.e. full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

`ifdef FIFO_METHOD2_COUNT_EN
    assign count = wr_ptr - rd_ptr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    fifo_method2_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (data_in),
        .re    (rd_acc),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (data_out)
    );

endmodule : fifo_method2

// File: tb/tb_fifo_method2.sv
module tb_fifo_method2;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
`ifdef FIFO_METHOD2_COUNT_EN
    logic [AW:0]   count;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: contents of the FIFO, oldest at the front.
    logic [DW-1:0] model_q[$];
    // Scoreboard: words the DUT must present on data_out after a read edge.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_data = '0;
    bit            mon_on = 1'b0;

    fifo_method2 #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
`ifdef FIFO_METHOD2_COUNT_EN
        .count    (count),
`endif
        .empty    (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: on every falling edge compare data_out against the scoreboard
    // (a pending read result) or the held value, and the flags against the model.
    always @(negedge clk) begin
        if (mon_on) begin
            if (exp_q.size() > 0) begin
                last_data = exp_q.pop_front();
                chk("rd_data", data_out, last_data);
            end else begin
                chk("hold_data", data_out, last_data);
            end
            chk("empty_flag", empty, model_q.size() == 0);
            chk("full_flag", full, model_q.size() == DEPTH);
`ifdef FIFO_METHOD2_COUNT_EN
            chk("count", count, model_q.size());
`endif
        end
    end

    // One clock of stimulus. The model is advanced with the pre-edge
    // occupancy, so a simultaneous read and write are each judged independently.
    task automatic cycle(input bit wr, input bit rd, input logic [DW-1:0] din);
        int unsigned occ;
        wr_en   = wr;
        rd_en   = rd;
        data_in = din;
        @(posedge clk);
        occ = model_q.size();
        if (rd && occ > 0) exp_q.push_back(model_q.pop_front());
        if (wr && occ < DEPTH) model_q.push_back(din);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_q.delete();
        exp_q.delete();
        last_data = '0;
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_data", data_out, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();
        mon_on = 1'b1;

        // Fill with 0x11..0x88, then one write that must be ignored.
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, 1'b0, 8'(i * 8'h11));
        end
        chk("fill_full", full, 1);
        chk("fill_empty", empty, 0);
        cycle(1'b1, 1'b0, 8'hFF);
        chk("ovf_full", full, 1);

        // Drain; the monitor checks 0x11..0x88 in order.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, '0);
        end
        chk("drain_data", data_out, 8'h88);
        chk("drain_empty", empty, 1);

        // Underflow: reads while empty leave data_out at 0x88.
        repeat (3) cycle(1'b0, 1'b1, '0);
        chk("udf_data", data_out, 8'h88);
        chk("udf_empty", empty, 1);

        // Simultaneous from empty: only the write lands.
        cycle(1'b1, 1'b1, 8'h5A);
        chk("simul_empty_flag", empty, 0);
        chk("simul_empty_data", data_out, 8'h88);
        cycle(1'b0, 1'b1, '0);
        chk("simul_empty_rd", data_out, 8'h5A);

        // Four stored, then six simultaneous cycles: occupancy stays at four.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'hA0 + i));
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, 8'(8'hB0 + i));
            chk("simul_occ_empty", empty, 0);
            chk("simul_occ_full", full, 0);
        end
        chk("simul_last_rd", data_out, 8'hB1);

        // Random mixed traffic; pointers wrap several times.
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        // Mid-burst reset: queue up data and a read, then reset before it settles.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'($urandom));
        cycle(1'b1, 1'b1, 8'h3C);
        do_reset();
        cycle(1'b1, 1'b0, 8'hA5);
        cycle(1'b0, 1'b1, '0);
        chk("post_rst_data", data_out, 8'hA5);
        chk("post_rst_empty", empty, 1);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_method2
